// File: rtl/mano_io_ctrl_pkg.sv
// rtl/mano_io_ctrl_pkg.sv - shared widths and FSM encodings for the MANO terminal I/O controller
//
// Purpose: default I/O byte width and FIFO depth, plus the state encodings
//          of the input-side and output-side handshake FSMs.
// Ports:   none (package).

package mano_io_ctrl_pkg;

  localparam int IOW_DEFAULT   = 8;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic {
    IN_IDLE  = 1'b0,
    IN_GUARD = 1'b1
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_INIT  = 2'd0,
    OUT_ARMED = 2'd1,
    OUT_GUARD = 2'd2
  } out_state_e;

endpackage

// File: rtl/mano_io_ctrl_io_fifo.sv
// rtl/mano_io_ctrl_io_fifo.sv - show-ahead byte FIFO used on both sides of the I/O controller
//
// Purpose: DEPTH-entry FIFO with head always visible on dout_o.
//          A push while full or a pop while empty is ignored.
// Ports:   clk_i, rst_ni (async active-low)
//          push_i, din_i       write side
//          pop_i, dout_o       read side (dout_o = head)
//          full_o, empty_o     status flags
//          count_o             occupancy, 0..DEPTH

module io_fifo #(
  parameter int DEPTH = 4,
  parameter int IOW   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [IOW-1:0]           din_i,
  output logic [IOW-1:0]           dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IOW-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/mano_io_ctrl.sv
// rtl/mano_io_ctrl.sv - MANO terminal I/O controller between INPR/OUTR/FGI/FGO and external byte streams
//
// Purpose: input side buffers rx bytes and loads them into INPR (setting FGI)
//          whenever FGI is clear; output side captures OUTR when the CPU clears
//          FGO, queues it for the tx sink, then sets FGO again.
// Ports:   mclk, mrst (async active-low)
//          rx_data/rx_valid/rx_ready      external producer
//          tx_data/tx_valid/tx_ready      external consumer
//          fgi, fgo, outr                 datapath flags / OUTR
//          inpr_data, inpr_ld, fgi_set    INPR load interface
//          fgo_set                        FGO set strobe
//          in_count, out_count            FIFO occupancies

module mano_io_ctrl
  import mano_io_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IOW   = IOW_DEFAULT
) (
  input  logic                   mclk,
  input  logic                   mrst,
  input  logic [IOW-1:0]         rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [IOW-1:0]         tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   fgi,
  input  logic                   fgo,
  input  logic [IOW-1:0]         outr,
  output logic [IOW-1:0]         inpr_data,
  output logic                   inpr_ld,
  output logic                   fgi_set,
  output logic                   fgo_set,
  output logic [$clog2(DEPTH):0] in_count,
  output logic [$clog2(DEPTH):0] out_count
);

  in_state_e  in_state_q, in_state_d;
  out_state_e out_state_q, out_state_d;

  logic in_full, in_empty, in_pop;
  logic out_full, out_empty, out_push;

  assign rx_ready = !in_full;
  assign tx_valid = !out_empty;

  io_fifo #(.DEPTH(DEPTH), .IOW(IOW)) u_in_fifo (
    .clk_i   (mclk),
    .rst_ni  (mrst),
    .push_i  (rx_valid && !in_full),
    .pop_i   (in_pop),
    .din_i   (rx_data),
    .dout_o  (inpr_data),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (in_count)
  );

  io_fifo #(.DEPTH(DEPTH), .IOW(IOW)) u_out_fifo (
    .clk_i   (mclk),
    .rst_ni  (mrst),
    .push_i  (out_push),
    .pop_i   (tx_ready && !out_empty),
    .din_i   (outr),
    .dout_o  (tx_data),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_INIT;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
    end
  end

  // The guard state gives the datapath one cycle to reflect fgi_set before
  // the flag is looked at again.
  always_comb begin
    in_state_d = in_state_q;
    in_pop     = 1'b0;
    inpr_ld    = 1'b0;
    fgi_set    = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (!fgi && !in_empty) begin
          in_pop     = 1'b1;
          inpr_ld    = 1'b1;
          fgi_set    = 1'b1;
          in_state_d = IN_GUARD;
        end
      end
      IN_GUARD: in_state_d = IN_IDLE;
      default:  in_state_d = IN_IDLE;
    endcase
  end

  // OUT_INIT is the reset state, so its announcement strobe is qualified
  // with mrst to stay quiet while reset is held. A full FIFO leaves FGO
  // clear, which keeps the CPU spinning in its SKO loop.
  always_comb begin
    out_state_d = out_state_q;
    out_push    = 1'b0;
    fgo_set     = 1'b0;
    case (out_state_q)
      OUT_INIT: begin
        if (mrst) begin
          fgo_set     = 1'b1;
          out_state_d = OUT_GUARD;
        end
      end
      OUT_ARMED: begin
        if (!fgo && !out_full) begin
          out_push    = 1'b1;
          fgo_set     = 1'b1;
          out_state_d = OUT_GUARD;
        end
      end
      OUT_GUARD: out_state_d = OUT_ARMED;
      default:   out_state_d = OUT_INIT;
    endcase
  end

endmodule

// File: tb/tb_mano_io_ctrl.sv
// tb/tb_mano_io_ctrl.sv - directed self-checking bench for mano_io_ctrl

module tb_mano_io_ctrl;

  logic       mclk;
  logic       mrst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       fgi;
  logic       fgo = 1'b0;
  logic [7:0] outr;
  logic [7:0] inpr_data;
  logic       inpr_ld;
  logic       fgi_set;
  logic       fgo_set;
  logic [2:0] in_count;
  logic [2:0] out_count;
  logic       cpu_clr_fgo;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_tx [4];

  mano_io_ctrl #(.DEPTH(4), .IOW(8)) dut (
    .mclk      (mclk),
    .mrst      (mrst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .fgi       (fgi),
    .fgo       (fgo),
    .outr      (outr),
    .inpr_data (inpr_data),
    .inpr_ld   (inpr_ld),
    .fgi_set   (fgi_set),
    .fgo_set   (fgo_set),
    .in_count  (in_count),
    .out_count (out_count)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Datapath FGO flag: set by the controller, cleared by the CPU's OUT.
  always @(posedge mclk) begin
    if (fgo_set)          fgo <= 1'b1;
    else if (cpu_clr_fgo) fgo <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // CPU OUT instruction: load OUTR and clear FGO, then expect the capture.
  task automatic cpu_out(input logic [7:0] b);
    outr        = b;
    cpu_clr_fgo = 1'b1;
    @(negedge mclk);
    cpu_clr_fgo = 1'b0;
    check("cpu_out_fgo_set", {31'd0, fgo_set}, 32'd1);
    @(negedge mclk);
  endtask

  initial begin
    exp_tx      = '{8'hB1, 8'hB2, 8'hB3, 8'hC4};
    mrst        = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    tx_ready    = 1'b0;
    fgi         = 1'b0;
    outr        = 8'h00;
    cpu_clr_fgo = 1'b0;

    // Reset state
    @(negedge mclk);
    check("rst_rx_ready",  {31'd0, rx_ready}, 32'd1);
    check("rst_tx_valid",  {31'd0, tx_valid}, 32'd0);
    check("rst_in_count",  {29'd0, in_count}, 32'd0);
    check("rst_out_count", {29'd0, out_count}, 32'd0);
    check("rst_fgo_set",   {31'd0, fgo_set}, 32'd0);
    check("rst_inpr_ld",   {31'd0, inpr_ld}, 32'd0);
    check("rst_inpr_data", {24'd0, inpr_data}, 32'd0);

    // Release: single OUT_INIT announcement, no capture
    @(negedge mclk);
    mrst = 1'b1;
    #1;
    check("init_fgo_set", {31'd0, fgo_set}, 32'd1);
    @(negedge mclk);
    check("init_guard_fgo_set", {31'd0, fgo_set}, 32'd0);
    check("init_out_count",     {29'd0, out_count}, 32'd0);
    @(negedge mclk);
    check("init_armed_fgo_set", {31'd0, fgo_set}, 32'd0);
    check("init_out_count2",    {29'd0, out_count}, 32'd0);

    // Two input bytes with fgi held low
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(negedge mclk);
    check("in41_inpr_ld",   {31'd0, inpr_ld}, 32'd1);
    check("in41_fgi_set",   {31'd0, fgi_set}, 32'd1);
    check("in41_inpr_data", {24'd0, inpr_data}, 32'h41);
    check("in41_in_count",  {29'd0, in_count}, 32'd1);
    rx_data = 8'h42;
    @(negedge mclk);
    check("in_guard_inpr_ld", {31'd0, inpr_ld}, 32'd0);
    check("in_guard_count",   {29'd0, in_count}, 32'd1);
    rx_valid = 1'b0;
    @(negedge mclk);
    check("in42_inpr_ld",   {31'd0, inpr_ld}, 32'd1);
    check("in42_inpr_data", {24'd0, inpr_data}, 32'h42);
    @(negedge mclk);
    check("in_drained_count", {29'd0, in_count}, 32'd0);
    check("in_drained_ld",    {31'd0, inpr_ld}, 32'd0);

    // fgi held high: fill input FIFO, fifth byte refused
    fgi      = 1'b1;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(8'h10 + i);
      @(negedge mclk);
    end
    check("full_in_count", {29'd0, in_count}, 32'd4);
    check("full_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("full_no_ld",    {31'd0, inpr_ld}, 32'd0);
    rx_valid = 1'b0;
    fgi      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("order_inpr_ld",   {31'd0, inpr_ld}, 32'd1);
      check("order_inpr_data", {24'd0, inpr_data}, 32'h10 + i);
      @(negedge mclk);
      @(negedge mclk);
    end
    check("order_in_count", {29'd0, in_count}, 32'd0);
    check("order_no_fifth", {31'd0, inpr_ld}, 32'd0);

    // Single OUT capture
    cpu_out(8'h5A);
    check("out1_count",    {29'd0, out_count}, 32'd1);
    check("out1_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("out1_tx_data",  {24'd0, tx_data}, 32'h5A);
    check("out1_guard",    {31'd0, fgo_set}, 32'd0);

    // Fill output FIFO, then a fifth OUT stalls
    cpu_out(8'hB1);
    cpu_out(8'hB2);
    cpu_out(8'hB3);
    check("outfull_count", {29'd0, out_count}, 32'd4);
    outr        = 8'hC4;
    cpu_clr_fgo = 1'b1;
    @(negedge mclk);
    cpu_clr_fgo = 1'b0;
    check("stall_fgo_set", {31'd0, fgo_set}, 32'd0);
    check("stall_count",   {29'd0, out_count}, 32'd4);
    @(negedge mclk);
    check("stall_fgo_set2", {31'd0, fgo_set}, 32'd0);
    check("stall_head",     {24'd0, tx_data}, 32'h5A);
    tx_ready = 1'b1;
    @(negedge mclk);
    tx_ready = 1'b0;
    check("unstall_count",   {29'd0, out_count}, 32'd3);
    check("unstall_fgo_set", {31'd0, fgo_set}, 32'd1);
    check("unstall_head",    {24'd0, tx_data}, 32'hB1);
    @(negedge mclk);
    check("refill_count",   {29'd0, out_count}, 32'd4);
    check("refill_fgo_set", {31'd0, fgo_set}, 32'd0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_tx_valid", {31'd0, tx_valid}, 32'd1);
      check("drain_tx_data",  {24'd0, tx_data}, {24'd0, exp_tx[i]});
      @(negedge mclk);
    end
    tx_ready = 1'b0;
    check("drained_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("drained_count",    {29'd0, out_count}, 32'd0);

    // Reset mid-transfer
    fgi      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h21;
    @(negedge mclk);
    rx_data = 8'h22;
    @(negedge mclk);
    rx_valid = 1'b0;
    cpu_out(8'h33);
    cpu_out(8'h34);
    cpu_out(8'h35);
    check("pre_rst_in_count",  {29'd0, in_count}, 32'd2);
    check("pre_rst_out_count", {29'd0, out_count}, 32'd3);
    mrst = 1'b0;
    #1;
    check("mid_rst_in_count",  {29'd0, in_count}, 32'd0);
    check("mid_rst_out_count", {29'd0, out_count}, 32'd0);
    check("mid_rst_tx_valid",  {31'd0, tx_valid}, 32'd0);
    check("mid_rst_rx_ready",  {31'd0, rx_ready}, 32'd1);
    check("mid_rst_fgo_set",   {31'd0, fgo_set}, 32'd0);
    @(negedge mclk);
    mrst = 1'b1;
    #1;
    check("reinit_fgo_set", {31'd0, fgo_set}, 32'd1);
    @(negedge mclk);
    check("reinit_guard",     {31'd0, fgo_set}, 32'd0);
    check("reinit_out_count", {29'd0, out_count}, 32'd0);
    check("reinit_tx_valid",  {31'd0, tx_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
